cdc_fifo_wr_arbiter: RTL and testbench

Round-robin arbiter sharing the write port of one `cdc_fifo` among NCH requester streams in the write clock domain. It grants one requester at a time, forwards its beats into the FIFO tagged with channel ID and end-of-segment flag, and releases on packet end or a burst limit. The read side de-multiplexes by the tag.

---
 rtl/cdc_fifo_arb_pkg.sv | 30 +++
 rtl/cdc_fifo_wr_arbiter_if.sv | 26 ++
 rtl/cdc_rr_pick.sv | 30 +++
 rtl/cdc_fifo_wr_arbiter.sv | 125 ++++++++++++
 tb/tb_cdc_fifo_wr_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdc_fifo_arb_pkg.sv
// Shared definitions for the cdc_fifo write-port arbiter: state encoding,
// width helper and wr_data field offsets.
package cdc_fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // wr_data layout: {ch, last, data}
   localparam int unsigned WR_DATA_LSB = 0;

   function automatic int unsigned wr_last_pos(input int unsigned dw);
      return dw;
   endfunction

   function automatic int unsigned wr_ch_lsb(input int unsigned dw);
      return dw + 1;
   endfunction

endpackage

// File: rtl/cdc_fifo_wr_arbiter_if.sv
// Requester and FIFO write-port signals of the arbiter. The master modport is
// the arbiter's view; slave is the requesters/FIFO side.
interface cdc_fifo_wr_arbiter_if #(
   parameter int unsigned DW  = 32,
   parameter int unsigned NCH = 4,
   localparam int unsigned CHW = cdc_fifo_arb_pkg::clog2(NCH),
   localparam int unsigned FW  = DW + CHW + 1
);
   logic [NCH*DW-1:0] in_data;
   logic [NCH-1:0]    in_last;
   logic [NCH-1:0]    in_valid;
   logic [NCH-1:0]    in_ready;
   logic              wr_en;
   logic [FW-1:0]     wr_data;
   logic              wr_full;

   modport master (
      input  in_data, in_last, in_valid, wr_full,
      output in_ready, wr_en, wr_data
   );

   modport slave (
      output in_data, in_last, in_valid, wr_full,
      input  in_ready, wr_en, wr_data
   );
endinterface

// File: rtl/cdc_rr_pick.sv
// Combinational rotating-priority picker: first set req bit at or after ptr,
// wrapping modulo NCH.
module cdc_rr_pick #(
   parameter int unsigned NCH = 4,
   parameter int unsigned CHW = 2
) (
   input  logic [NCH-1:0] req,
   input  logic [CHW-1:0] ptr,
   output logic [CHW-1:0] gnt_idx,
   output logic           gnt_any
);
   always_comb begin
      logic found;
      logic [CHW-1:0] idx;
      int unsigned idx_full;
      gnt_idx  = '0;
      gnt_any  = |req;
      found    = 1'b0;
      idx      = '0;
      idx_full = 0;
      for (int unsigned k = 0; k < NCH; k++) begin
         idx_full = (32'(ptr) + k) % NCH;
         idx      = CHW'(idx_full);
         if (!found && req[idx]) begin
            gnt_idx = idx;
            found   = 1'b1;
         end
      end
   end
endmodule

// File: rtl/cdc_fifo_wr_arbiter.sv
// Round-robin arbiter for the cdc_fifo write port. Define CDC_FIFO_ARB_PKTLOCK_EN
// to hold a grant for a whole packet (up to MAXBURST beats); otherwise one beat per grant.
module cdc_fifo_wr_arbiter
   import cdc_fifo_arb_pkg::*;
#(
   parameter int unsigned DW       = 32,
   parameter int unsigned NCH      = 4,
   parameter int unsigned MAXBURST = 16,
   localparam int unsigned CHW     = clog2(NCH)
) (
   input  logic                  clk,
   input  logic                  rst,
   cdc_fifo_wr_arbiter_if.master bus,
   output logic                  busy,
   output logic [CHW-1:0]        cur_ch
);
   localparam int unsigned LAST_POS = wr_last_pos(DW);
   localparam int unsigned CH_LSB   = wr_ch_lsb(DW);

   arb_state_t     state, state_n;
   logic [CHW-1:0] ptr, ptr_n, g, g_n, g_inc, pick_idx;
   logic           pick_any, xfer, rel, valid_g, last_g, last_w;
   logic [DW-1:0]  data_g;

   cdc_rr_pick #(.NCH(NCH), .CHW(CHW)) u_pick (
      .req     (bus.in_valid),
      .ptr     (ptr),
      .gnt_idx (pick_idx),
      .gnt_any (pick_any)
   );

   always_comb begin
      data_g  = '0;
      valid_g = 1'b0;
      last_g  = 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (g == CHW'(i)) begin
            data_g  = bus.in_data[i*DW +: DW];
            valid_g = bus.in_valid[i];
            last_g  = bus.in_last[i];
         end
      end
   end

   assign xfer  = (state == GRANT) && valid_g && !bus.wr_full;
   assign g_inc = (g == CHW'(NCH-1)) ? '0 : g + 1'b1;

`ifdef CDC_FIFO_ARB_PKTLOCK_EN
   localparam int unsigned CW = clog2(MAXBURST);
   logic [CW-1:0] cnt, cnt_n;
   logic          seg_end;

   assign seg_end = (cnt == CW'(MAXBURST-1));
   assign last_w  = last_g | seg_end;
   // A grant taken but withdrawn before its first beat is dropped; gaps after it are waited out.
   assign rel     = xfer ? (last_g | seg_end) : ((cnt == '0) && !valid_g);
`else
   assign last_w  = last_g;
   assign rel     = xfer || !valid_g;
`endif

   always_comb begin
      bus.wr_data                       = '0;
      bus.wr_data[WR_DATA_LSB +: DW]    = data_g;
      bus.wr_data[LAST_POS]             = last_w;
      bus.wr_data[CH_LSB +: CHW]        = g;
      bus.in_ready                      = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (xfer && (g == CHW'(i))) bus.in_ready[i] = 1'b1;
      end
   end

   assign bus.wr_en = xfer;
   assign busy      = (state == GRANT);
   assign cur_ch    = g;

   always_comb begin
      state_n = state;
      g_n     = g;
      ptr_n   = ptr;
`ifdef CDC_FIFO_ARB_PKTLOCK_EN
      cnt_n   = cnt;
`endif
      case (state)
         IDLE: begin
            if (pick_any) begin
               state_n = GRANT;
               g_n     = pick_idx;
`ifdef CDC_FIFO_ARB_PKTLOCK_EN
               cnt_n   = '0;
`endif
            end
         end
         GRANT: begin
            if (rel) begin
               state_n = IDLE;
               ptr_n   = g_inc;
`ifdef CDC_FIFO_ARB_PKTLOCK_EN
               cnt_n   = '0;
            end else if (xfer) begin
               cnt_n   = cnt + 1'b1;
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
         g     <= '0;
`ifdef CDC_FIFO_ARB_PKTLOCK_EN
         cnt   <= '0;
`endif
      end else begin
         state <= state_n;
         ptr   <= ptr_n;
         g     <= g_n;
`ifdef CDC_FIFO_ARB_PKTLOCK_EN
         cnt   <= cnt_n;
`endif
      end
   end
endmodule

// File: tb/tb_cdc_fifo_wr_arbiter.sv
// Bench for cdc_fifo_wr_arbiter: per-cycle vector table, directed stream
// sequences and a randomized run against a packet-level scoreboard.
module tb_cdc_fifo_wr_arbiter;
   import cdc_fifo_arb_pkg::*;

   localparam int unsigned DW = 32, NCH = 4, MAXBURST = 16;
   localparam int unsigned CHW = clog2(NCH), FW = DW + CHW + 1;
`ifdef CDC_FIFO_ARB_PKTLOCK_EN
   localparam bit LOCK = 1'b1;
   localparam int MAXLEN = 40;
`else
   localparam bit LOCK = 1'b0;
   localparam int MAXLEN = 3;
`endif

   logic clk = 1'b0;
   logic rst;
   logic busy;
   logic [CHW-1:0] cur_ch;
   always #5 clk = ~clk;

   cdc_fifo_wr_arbiter_if #(.DW(DW), .NCH(NCH)) bus ();

   cdc_fifo_wr_arbiter #(.DW(DW), .NCH(NCH), .MAXBURST(MAXBURST)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .busy   (busy),
      .cur_ch (cur_ch)
   );

   int tests, fails;

   typedef struct {
      logic [3:0] v, l;
      logic       f, en, b;
      logic [1:0] ch;
   } vec_t;
   vec_t tbl[$];

   int          rec_ch[$], exp_ch[$];
   bit          rec_last[$], exp_last[$];
   logic [31:0] rec_data[$], exp_data[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] tdata(input int c);
      return 32'hC0DE_0000 + 32'(c);
   endfunction

   function automatic logic [31:0] sdata(input int c, input int k);
      return {4'(c), 28'(k)};
   endfunction

   task automatic add(input logic [3:0] v, input logic [3:0] l, input logic f,
                      input logic en, input logic b, input logic [1:0] ch);
      vec_t r;
      r.v = v; r.l = l; r.f = f; r.en = en; r.b = b; r.ch = ch;
      tbl.push_back(r);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = '0;
      bus.in_last  = '0;
      bus.wr_full  = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic push_exp(input int c, input bit l, input logic [31:0] d);
      exp_ch.push_back(c);
      exp_last.push_back(l);
      exp_data.push_back(d);
   endtask

   task automatic run_stream(input int ca, input int ta, input int pa,
                             input int cb, input int tb_n, input int pb);
      int ka, kb, cyc;
      logic [NCH-1:0] acc;
      ka = 0; kb = 0; cyc = 0;
      rec_ch.delete(); rec_last.delete(); rec_data.delete();
      while (!(ka == ta && kb == tb_n) && cyc < 600) begin
         bus.in_valid = '0;
         bus.in_last  = '0;
         bus.in_valid[ca] = (ka < ta);
         bus.in_last[ca]  = ((ka + 1) % pa == 0);
         bus.in_data[ca*DW +: DW] = sdata(ca, ka + 1);
         bus.in_valid[cb] = (kb < tb_n);
         bus.in_last[cb]  = ((kb + 1) % pb == 0);
         bus.in_data[cb*DW +: DW] = sdata(cb, kb + 1);
         @(negedge clk);
         acc = bus.in_ready;
         if (bus.wr_en) begin
            rec_ch.push_back(int'(bus.wr_data[FW-1 -: CHW]));
            rec_last.push_back(bus.wr_data[DW]);
            rec_data.push_back(bus.wr_data[DW-1:0]);
         end
         @(posedge clk);
         #1 cyc++;
         if (acc[ca]) ka++;
         if (acc[cb]) kb++;
      end
      chk("stream_done", 64'(ka == ta && kb == tb_n), 64'd1);
      bus.in_valid = '0;
      bus.in_last  = '0;
   endtask

   task automatic compare_seq(input string name);
      chk({name, "_len"}, 64'(rec_ch.size()), 64'(exp_ch.size()));
      for (int i = 0; i < rec_ch.size() && i < exp_ch.size(); i++) begin
         chk($sformatf("%s_ch%0d", name, i), 64'(rec_ch[i]), 64'(exp_ch[i]));
         chk($sformatf("%s_last%0d", name, i), 64'(rec_last[i]), 64'(exp_last[i]));
         chk($sformatf("%s_data%0d", name, i), 64'(rec_data[i]), 64'(exp_data[i]));
      end
      exp_ch.delete(); exp_last.delete(); exp_data.delete();
   endtask

   // Randomized run: each channel offers packets beat by beat, holding valid until ready.
   bit          pend[NCH];
   int          plen[NCH], pbeat[NCH], pseq[NCH];
   logic [31:0] pdat[NCH];
   bit          plast[NCH], pseg[NCH];

   task automatic run_random();
      logic [NCH-1:0] acc;
      int c, nbeats, cyc;
      bit any_pend, exp_l;
      nbeats = 0;
      for (int i = 0; i < NCH; i++) begin
         pend[i] = 0; plen[i] = 1; pbeat[i] = 0; pseq[i] = 0;
      end
      cyc = 0;
      any_pend = 1'b1;
      while (cyc < 1500 || (any_pend && cyc < 2200)) begin
         for (int i = 0; i < NCH; i++) begin
            if (!pend[i] && cyc < 1500 && $urandom_range(0, 3) != 0) begin
               if (pbeat[i] == 0) plen[i] = int'($urandom_range(1, MAXLEN));
               pseq[i]++;
               pdat[i]  = sdata(i, pseq[i]);
               plast[i] = (pbeat[i] + 1 == plen[i]);
               pseg[i]  = ((pbeat[i] + 1) % MAXBURST == 0);
               pend[i]  = 1'b1;
               bus.in_data[i*DW +: DW] = pdat[i];
               bus.in_last[i]  = plast[i];
               bus.in_valid[i] = 1'b1;
            end
         end
         bus.wr_full = ($urandom_range(0, 4) == 0);
         @(negedge clk);
         acc = bus.in_ready;
         if (bus.wr_en) begin
            c = int'(bus.wr_data[FW-1 -: CHW]);
            exp_l = plast[c] | (LOCK & pseg[c]);
            chk("rnd_offered", 64'(pend[c]), 64'd1);
            chk("rnd_not_full", 64'(bus.wr_full), 64'd0);
            chk("rnd_data", 64'(bus.wr_data[DW-1:0]), 64'(pdat[c]));
            chk("rnd_last", 64'(bus.wr_data[DW]), 64'(exp_l));
            chk("rnd_ready", 64'(bus.in_ready), 64'(4'b0001 << c));
         end else begin
            chk("rnd_ready_idle", 64'(bus.in_ready), 64'd0);
         end
         @(posedge clk);
         #1 cyc++;
         any_pend = 1'b0;
         for (int i = 0; i < NCH; i++) begin
            if (acc[i]) begin
               pend[i] = 1'b0;
               bus.in_valid[i] = 1'b0;
               pbeat[i]++;
               if (pbeat[i] == plen[i]) pbeat[i] = 0;
               nbeats++;
            end
            if (pend[i]) any_pend = 1'b1;
         end
      end
      bus.wr_full = 1'b0;
      chk("rnd_drained", 64'(any_pend), 64'd0);
      chk("rnd_progress", 64'(nbeats > 200), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]    ch;
      logic [FW-1:0] exp_wd;
      logic [3:0]    exp_rdy;
      int            n, cyc;
      tests = 0;
      fails = 0;
      rst = 1'b1;
      bus.in_valid = '0;
      bus.in_last  = '0;
      bus.wr_full  = 1'b0;
      bus.in_data  = '0;
      for (int i = 0; i < NCH; i++) bus.in_data[i*DW +: DW] = tdata(i);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_cur_ch", 64'(cur_ch), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_wr_data", 64'(bus.wr_data), 64'({2'd0, 1'b0, tdata(0)}));
      @(posedge clk);
      #1 rst = 1'b0;

      //   v        l        f     en    busy  ch
      add(4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0);
`ifdef CDC_FIFO_ARB_PKTLOCK_EN
      add(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
      add(4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd2);
      add(4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd2);
      add(4'b0100, 4'b0100, 1'b0, 1'b1, 1'b1, 2'd2);
      add(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2);
      add(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2);
      add(4'b0010, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd1);
      for (int i = 0; i < 5; i++) add(4'b0010, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1);
      add(4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1, 2'd1);
`else
      add(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
      add(4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd2);
      add(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2);
      add(4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd2);
      add(4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd2);
      add(4'b0100, 4'b0100, 1'b0, 1'b1, 1'b1, 2'd2);
      add(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2);
      add(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2);
      for (int i = 0; i < 5; i++) add(4'b0010, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1);
      add(4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1, 2'd1);
`endif
      add(4'b1001, 4'b1001, 1'b0, 1'b0, 1'b0, 2'd1);
      add(4'b1001, 4'b1001, 1'b0, 1'b1, 1'b1, 2'd3);
      add(4'b1001, 4'b1001, 1'b0, 1'b0, 1'b0, 2'd3);
      add(4'b1001, 4'b1001, 1'b0, 1'b1, 1'b1, 2'd0);
      add(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);

      foreach (tbl[i]) begin
         bus.in_valid = tbl[i].v;
         bus.in_last  = tbl[i].l;
         bus.wr_full  = tbl[i].f;
         @(negedge clk);
         ch      = tbl[i].ch;
         exp_wd  = {ch, tbl[i].l[ch], tdata(int'(ch))};
         exp_rdy = tbl[i].en ? (4'b0001 << ch) : 4'b0000;
         chk($sformatf("vec%0d_wr_en", i), 64'(bus.wr_en), 64'(tbl[i].en));
         chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(tbl[i].b));
         chk($sformatf("vec%0d_cur_ch", i), 64'(cur_ch), 64'(ch));
         chk($sformatf("vec%0d_in_ready", i), 64'(bus.in_ready), 64'(exp_rdy));
         chk($sformatf("vec%0d_wr_data", i), 64'(bus.wr_data), 64'(exp_wd));
         @(posedge clk);
         #1;
      end
      bus.wr_full = 1'b0;

      // Reset asserted while the second beat of a channel-1 packet is on the port.
      do_reset();
      bus.in_valid = 4'b0010;
      bus.in_last  = 4'b0000;
      n = 0; cyc = 0;
      while (n < 2 && cyc < 50) begin
         @(negedge clk);
         if (bus.wr_en) n++;
         if (n < 2) begin
            @(posedge clk);
            #1 cyc++;
         end
      end
      chk("rstmid_beat2_reached", 64'(n), 64'd2);
      rst = 1'b1;
      #1;
      chk("rstmid_wr_en", 64'(bus.wr_en), 64'd0);
      chk("rstmid_busy", 64'(busy), 64'd0);
      chk("rstmid_in_ready", 64'(bus.in_ready), 64'd0);
      bus.in_valid = 4'b1111;
      bus.in_last  = 4'b1111;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rstmid_idle_busy", 64'(busy), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk("rstmid_ptr0_busy", 64'(busy), 64'd1);
      chk("rstmid_ptr0_ch", 64'(cur_ch), 64'd0);

      // 40-beat packet on channel 1 against 1-beat packets on channel 2.
      do_reset();
      run_stream(1, 40, 40, 2, LOCK ? 2 : 39, 1);
      begin
         int j;
         j = 1;
         for (int k = 1; k <= 40; k++) begin
            push_exp(1, (LOCK && (k % MAXBURST == 0)) || k == 40, sdata(1, k));
            if (k < 40 && (!LOCK || (k % MAXBURST == 0))) begin
               push_exp(2, 1'b1, sdata(2, j));
               j++;
            end
         end
      end
      compare_seq("burst");

      // Channels 0 and 3 each with one 2-beat packet.
      do_reset();
      run_stream(0, 2, 2, 3, 2, 2);
`ifdef CDC_FIFO_ARB_PKTLOCK_EN
      push_exp(0, 1'b0, sdata(0, 1));
      push_exp(0, 1'b1, sdata(0, 2));
      push_exp(3, 1'b0, sdata(3, 1));
      push_exp(3, 1'b1, sdata(3, 2));
`else
      push_exp(0, 1'b0, sdata(0, 1));
      push_exp(3, 1'b0, sdata(3, 1));
      push_exp(0, 1'b1, sdata(0, 2));
      push_exp(3, 1'b1, sdata(3, 2));
`endif
      compare_seq("pair");

      do_reset();
      run_random();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
